// File: rtl/uart_tx_ctrl_p.sv
// UART transmit controller: pops a registered-output FIFO and serialises each word
// onto rs232_tx with configurable data width, parity and stop bits.
module uart_tx_ctrl_p #(
  parameter int CLK_FREQ  = 20000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 fifo_rdreq,
  output logic                 rs232_tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = 4;

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO  = 4'd0;
  localparam logic [BIT_W-1:0] BIT_ONE   = 4'd1;
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  generate
    if ((DIV < 2) || (DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY < 0) || (PARITY > 2) ||
        (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_param_check
      $error("uart_tx_ctrl_p: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_FETCH = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_PAR   = 3'd5,
    S_STOP  = 3'd6
  } state_t;

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [BIT_W-1:0]     bit_r, bit_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 par_r, par_s;
  logic                 line_s, rdreq_s, done_s, busy_s;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    calc_parity = (^d) ^ ((PARITY == 1) ? 1'b1 : 1'b0);
  endfunction

  // Next-state, counters and the next value of every registered output.
  always_comb begin
    state_s = state_r;
    cnt_s   = CNT_ZERO;
    bit_s   = bit_r;
    shift_s = shift_r;
    par_s   = par_r;
    rdreq_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (tx_start) begin
          state_s = S_REQ;
          rdreq_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ:   state_s = S_FETCH;
      S_FETCH: begin
        shift_s = tx_data;
        par_s   = calc_parity(tx_data);
        state_s = S_START;
      end
      S_START: begin
        if (cnt_r == CNT_LAST) begin
          state_s = S_DATA;
          bit_s   = BIT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_r == CNT_LAST) begin
          if (bit_r == DATA_LAST) begin
            bit_s   = BIT_ZERO;
            state_s = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_s   = bit_r + BIT_ONE;
            shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_PAR: begin
        if (cnt_r == CNT_LAST) begin
          state_s = S_STOP;
          bit_s   = BIT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_STOP: begin
        if (cnt_r == CNT_LAST) begin
          if (bit_r == STOP_LAST) begin
            state_s = S_IDLE;
            bit_s   = BIT_ZERO;
          end else begin
            bit_s = bit_r + BIT_ONE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = S_IDLE;
        bit_s   = BIT_ZERO;
      end
    endcase

    // Line level is derived from the next state so the output register leads the FSM.
    case (state_s)
      S_START: line_s = 1'b0;
      S_DATA:  line_s = shift_s[0];
      S_PAR:   line_s = par_s;
      default: line_s = 1'b1;
    endcase
    done_s = (state_s == S_STOP) && (cnt_s == CNT_LAST) && (bit_s == STOP_LAST);
    busy_s = (state_s != S_IDLE);
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= CNT_ZERO;
      bit_r      <= BIT_ZERO;
      shift_r    <= {DATA_BITS{1'b0}};
      par_r      <= 1'b0;
      rs232_tx   <= 1'b1;
      fifo_rdreq <= 1'b0;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      bit_r      <= bit_s;
      shift_r    <= shift_s;
      par_r      <= par_s;
      rs232_tx   <= line_s;
      fifo_rdreq <= rdreq_s;
      busy       <= busy_s;
      tx_done    <= done_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl_p.sv
// Bench for uart_tx_ctrl_p: four instances (8N1, 7E2, 7O2, 9N1, all DIV=10) fed by
// registered-output FIFO models; expected words go through a scoreboard queue.
module tb_uart_tx_ctrl_p;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame formats of the four instances
  int nb [4] = '{8, 7, 7, 9};
  int pm [4] = '{0, 2, 1, 0};
  int st [4] = '{1, 2, 2, 1};

  wire  [3:0] rdreq_v, line_v, busy_v, done_v, start_v;
  logic [8:0] dq [4];
  logic [8:0] fmem [4][8];
  int         wr_p [4] = '{0, 0, 0, 0};
  int         rd_p [4] = '{0, 0, 0, 0};
  logic [8:0] sb_q [$];

  assign start_v = {wr_p[3] != rd_p[3], wr_p[2] != rd_p[2], wr_p[1] != rd_p[1], wr_p[0] != rd_p[0]};

  // FIFO model: data appears the cycle after the pop request
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rdreq_v[i] === 1'b1) begin
        dq[i]   <= fmem[i][rd_p[i] % 8];
        rd_p[i] <= rd_p[i] + 1;
      end
    end
  end

  uart_tx_ctrl_p #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tx_data(dq[0][7:0]), .tx_start(start_v[0]),
    .fifo_rdreq(rdreq_v[0]), .rs232_tx(line_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx_ctrl_p #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .clk(clk), .rst(rst), .tx_data(dq[1][6:0]), .tx_start(start_v[1]),
    .fifo_rdreq(rdreq_v[1]), .rs232_tx(line_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx_ctrl_p #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst(rst), .tx_data(dq[2][6:0]), .tx_start(start_v[2]),
    .fifo_rdreq(rdreq_v[2]), .rs232_tx(line_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));
  uart_tx_ctrl_p #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1)) u_9n1 (
    .clk(clk), .rst(rst), .tx_data(dq[3]), .tx_start(start_v[3]),
    .fifo_rdreq(rdreq_v[3]), .rs232_tx(line_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]));

  task automatic push(input int id, input logic [8:0] v);
    fmem[id][wr_p[id] % 8] = v;
    wr_p[id] = wr_p[id] + 1;
    sb_q.push_back(v);
  endtask

  // Expected line level at offset 'off' cycles after the start bit begins
  function automatic logic exp_line(input int id, input logic [8:0] d, input int off);
    int b;
    b = off / 10;
    if (b == 0) return 1'b0;
    if (b <= nb[id]) return d[b-1];
    if ((pm[id] != 0) && (b == nb[id] + 1)) return (^d) ^ ((pm[id] == 1) ? 1'b1 : 1'b0);
    return 1'b1;
  endfunction

  task automatic wait_rdreq(input int id, output int t);
    int   n;
    logic bprev;
    n = 0;
    t = -1;
    bprev = busy_v[id];
    while ((n < 400) && (t < 0)) begin
      @(negedge clk);
      n++;
      if (rdreq_v[id] === 1'b1) begin
        t = cyc;
        checks++;
        if (bprev !== 1'b0) begin
          fails++;
          $display("FAIL rdreq_while_busy id=%0d cyc=%0d busy_before=%b required=0", id, cyc, bprev);
        end
      end else begin
        bprev = busy_v[id];
      end
    end
    checks++;
    if (t < 0) begin
      fails++;
      $display("FAIL rdreq_timeout id=%0d no pop within 400 cycles", id);
    end
  endtask

  task automatic run_frame(input int id, output int t, output logic [8:0] e);
    int   len;
    logic el, eb, ed;
    wait_rdreq(id, t);
    e = 9'h000;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    if (t < 0) return;
    len = 10 * (1 + nb[id] + ((pm[id] != 0) ? 1 : 0) + st[id]);
    checks++;
    if (busy_v[id] !== 1'b1) begin
      fails++;
      $display("FAIL busy_at_pop id=%0d got=%b required=1", id, busy_v[id]);
    end
    for (int c = t + 1; c <= t + len + 2; c++) begin
      @(negedge clk);
      el = (c < t + 2) ? 1'b1 : exp_line(id, e, c - t - 2);
      eb = (c <= t + len + 1) ? 1'b1 : 1'b0;
      ed = (c == t + len + 1) ? 1'b1 : 1'b0;
      checks += 4;
      if (line_v[id] !== el) begin
        fails++;
        $display("FAIL line id=%0d cyc=T+%0d got=%b required=%b", id, c - t, line_v[id], el);
      end
      if (busy_v[id] !== eb) begin
        fails++;
        $display("FAIL busy id=%0d cyc=T+%0d got=%b required=%b", id, c - t, busy_v[id], eb);
      end
      if (done_v[id] !== ed) begin
        fails++;
        $display("FAIL tx_done id=%0d cyc=T+%0d got=%b required=%b", id, c - t, done_v[id], ed);
      end
      if (rdreq_v[id] !== 1'b0) begin
        fails++;
        $display("FAIL extra_rdreq id=%0d cyc=T+%0d got=%b required=0", id, c - t, rdreq_v[id]);
      end
    end
  endtask

  // Independent receiver: samples mid-bit after seeing the start edge
  task automatic uart_rx(input int id, output logic [8:0] d, output logic pb, output bit ok);
    int n;
    ok = 1'b1;
    d  = 9'h000;
    pb = 1'b0;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((line_v[id] !== 1'b0) && (n < 400));
    if (line_v[id] !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (5) @(negedge clk);
    if (line_v[id] !== 1'b0) ok = 1'b0;
    for (int k = 0; k < nb[id]; k++) begin
      repeat (10) @(negedge clk);
      d[k] = line_v[id];
    end
    if (pm[id] != 0) begin
      repeat (10) @(negedge clk);
      pb = line_v[id];
      if (pb !== ((^d) ^ ((pm[id] == 1) ? 1'b1 : 1'b0))) ok = 1'b0;
    end
    for (int s = 0; s < st[id]; s++) begin
      repeat (10) @(negedge clk);
      if (line_v[id] !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (line_v !== 4'hF) begin fails++; $display("FAIL reset_line got=%b required=1111", line_v); end
    if (rdreq_v !== 4'h0) begin fails++; $display("FAIL reset_rdreq got=%b required=0000", rdreq_v); end
    if (busy_v !== 4'h0) begin fails++; $display("FAIL reset_busy got=%b required=0000", busy_v); end
    if (done_v !== 4'h0) begin fails++; $display("FAIL reset_done got=%b required=0000", done_v); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_8n1();
    int t;
    logic [8:0] e;
    push(0, 9'h0A5);
    run_frame(0, t, e);
  endtask

  task automatic test_parity(input int id, input logic pexp);
    int t;
    logic [8:0] e, d;
    logic pb;
    bit ok;
    push(id, 9'h035);
    fork
      run_frame(id, t, e);
      uart_rx(id, d, pb, ok);
    join
    checks += 3;
    if (pb !== pexp) begin fails++; $display("FAIL parity_bit id=%0d got=%b required=%b", id, pb, pexp); end
    if (ok !== 1'b1) begin fails++; $display("FAIL parity_frame id=%0d got=%b required=1", id, ok); end
    if (d !== e) begin fails++; $display("FAIL parity_data id=%0d got=%h required=%h", id, d, e); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t [3];
    int extra;
    logic [8:0] e;
    push(0, 9'h001);
    push(0, 9'h002);
    push(0, 9'h003);
    for (int i = 0; i < 3; i++) run_frame(0, t[i], e);
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (t[i] - t[i-1] !== 103) begin
        fails++;
        $display("FAIL pop_spacing idx=%0d got=%0d required=103", i, t[i] - t[i-1]);
      end
    end
    extra = 0;
    repeat (150) begin
      @(negedge clk);
      if (rdreq_v[0] === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin fails++; $display("FAIL b2b_extra_pops got=%0d required=0", extra); end
  endtask

  task automatic test_reset_mid_frame();
    int t, t2, cr;
    logic [8:0] e;
    push(0, 9'h05A);
    push(0, 9'h03C);
    wait_rdreq(0, t);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    repeat (45) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 3;
    if (line_v[0] !== 1'b1) begin fails++; $display("FAIL abort_line got=%b required=1", line_v[0]); end
    if (busy_v[0] !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b required=0", busy_v[0]); end
    if (rdreq_v[0] !== 1'b0) begin fails++; $display("FAIL abort_rdreq got=%b required=0", rdreq_v[0]); end
    rst = 1'b0;
    cr = cyc;
    run_frame(0, t2, e);
    checks++;
    if (t2 !== cr + 1) begin fails++; $display("FAIL abort_repop got=%0d required=%0d", t2, cr + 1); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_with_start();
    int t, cr;
    logic [8:0] e;
    push(0, 9'h077);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks += 2;
      if (rdreq_v[0] !== 1'b0) begin fails++; $display("FAIL rst_start_rdreq got=%b required=0", rdreq_v[0]); end
      if (busy_v[0] !== 1'b0) begin fails++; $display("FAIL rst_start_busy got=%b required=0", busy_v[0]); end
    end
    rst = 1'b0;
    cr = cyc;
    run_frame(0, t, e);
    checks++;
    if (t !== cr + 1) begin fails++; $display("FAIL rst_start_pop got=%0d required=%0d", t, cr + 1); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_nine_bit();
    int t;
    logic [8:0] e, d;
    logic pb;
    bit ok;
    push(3, 9'h1FF);
    fork
      run_frame(3, t, e);
      uart_rx(3, d, pb, ok);
    join
    checks += 2;
    if (d !== 9'h1FF) begin fails++; $display("FAIL nine_bit_data got=%h required=1ff", d); end
    if (ok !== 1'b1) begin fails++; $display("FAIL nine_bit_framing got=%b required=1", ok); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dq[i] = 9'h000;
    test_reset();
    test_frame_8n1();
    test_parity(1, 1'b0);
    test_parity(2, 1'b1);
    test_back_to_back();
    test_reset_mid_frame();
    test_reset_with_start();
    test_nine_bit();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_ctrl_p.md
Name: uart_tx_ctrl_p

Overview:
Parametrised UART transmit controller. It combines baud-tick generation, a FIFO-pop handshake, frame serialisation and status into one block. It drains a standard (registered-output) FIFO onto rs232_tx with configurable data width, parity and stop bits. It sits between the SDRAM-read FIFO and the board RS232 pin, and supports back-to-back frames with a single idle cycle between them.

Parameters:
CLK_FREQ, 20000000, clk frequency in Hz
BAUD, 9600, line rate in bit/s; DIV = CLK_FREQ/BAUD (integer division, must be >= 2, elaboration error otherwise)
DATA_BITS, 8, payload bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal values 1 or 2

Ports:
clk  input  1  single system clock; all logic on its rising edge
rst  input  1  reset, synchronous, active-high
tx_data  input  DATA_BITS  FIFO read data, valid the cycle after fifo_rdreq
tx_start  input  1  FIFO not-empty, active high
fifo_rdreq  output  1  one-cycle FIFO pop pulse, active high
rs232_tx  output  1  serial line, idles high
busy  output  1  high from the rdreq cycle through the last stop-bit cycle
tx_done  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, rs232_tx=1, fifo_rdreq=0, busy=0, tx_done=0, baud counter=0, bit counter=0. Reset wins over any simultaneous tx_start.
- Reset mid-frame: the frame is aborted. rs232_tx returns high on the next edge and the partial frame is not retried.
- States:
  - IDLE: rs232_tx=1. If tx_start=1, assert fifo_rdreq this cycle (registered, so visible in cycle T) and go to FETCH.
  - FETCH (1 cycle, T+1): latch tx_data into the shift register. Compute par = ^tx_data, inverted for odd parity. Go to START.
  - START: rs232_tx=0 for DIV cycles, beginning at T+2.
  - DATA: DATA_BITS bits, LSB first, each held for DIV cycles.
  - PAR: present only when PARITY != 0; DIV cycles.
  - STOP: rs232_tx=1 for STOP_BITS*DIV cycles. tx_done=1 on the last of these cycles, then go to IDLE.
- Baud counter: counts 0..DIV-1. It resets to 0 on every state entry, and the bit advances when the counter reaches DIV-1. The counter is sized clog2(DIV).
- Frame length (START through STOP): DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
- Back-to-back transfers: IDLE is always occupied for at least 1 cycle. Pop-to-pop spacing is frame length + 3 cycles.
- tx_start is ignored outside IDLE; deasserting it mid-frame has no effect.
- fifo_rdreq never asserts while busy, so there is no FIFO underflow by construction.
- Unused upper tx_data bits are not applicable; width is exactly DATA_BITS.
- Outputs rs232_tx, fifo_rdreq and tx_done are registered, with no combinational path from any input.

Test Plan:
1. Default-style frame: CLK_FREQ=1000000, BAUD=100000 (DIV=10), 8N1. FIFO holds 0xA5, tx_start=1 -> one rdreq pulse; from T+2 the line shows 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, each for 10 cycles; tx_done at T+101; busy high T..T+101.
2. Even parity, 7 data bits, 2 stop bits, DIV=10, data 0x35 -> parity bit 0 after the data bits, stop high for 20 cycles, frame length 110 cycles. With odd parity on the same data -> parity bit 1.
3. Back-to-back: FIFO holds 0x01,0x02,0x03 with tx_start held high, 8N1, DIV=10 -> exactly 3 rdreq pulses spaced 103 cycles apart and 3 correct frames; rdreq never asserts while busy=1.
4. Reset mid-frame: assert rst for 1 cycle during data bit 3 -> next edge gives rs232_tx=1, busy=0, state IDLE. With tx_start still 1, the next rdreq occurs exactly 1 cycle after rst deasserts, and the following frame is clean.
5. Simultaneous rst=1 and tx_start=1 in IDLE -> no rdreq; rdreq occurs in the first cycle after rst=0.
6. 9-bit mode: DATA_BITS=9, PARITY=0, data 9'h1FF -> 9 high data bits after the start bit; bench-side UART model with DIV=10 decodes 0x1FF with no framing error.
